// File: rtl/ysyx_220053_mem_arbiter.sv
// Two-requester (fetch / load-store) memory arbiter with round-robin grant,
// a single outstanding downstream transaction, and fetch-kill response dropping.
module ysyx_220053_mem_arbiter #(
   parameter int unsigned AW = 64,
   parameter int unsigned DW = 64
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [AW-1:0]     if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DW-1:0]     if_rdata,
   input  logic              if_kill,

   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [AW-1:0]     ls_addr,
   input  logic [DW-1:0]     ls_wdata,
   input  logic [DW/8-1:0]   ls_wmask,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DW-1:0]     ls_rdata,

   output logic              bus_req,
   output logic              bus_we,
   output logic [AW-1:0]     bus_addr,
   output logic [DW-1:0]     bus_wdata,
   output logic [DW/8-1:0]   bus_wmask,
   input  logic              bus_ready,
   input  logic              bus_resp,
   input  logic [DW-1:0]     bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
   typedef enum logic {OWN_IF, OWN_LS} owner_e;

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_owner_q, last_owner_d;
   logic              drop_q, drop_d;
   logic              we_q, we_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW/8-1:0]   wmask_q, wmask_d;

   logic              pick_ls;
   logic              grant_if, grant_ls;
   logic              resp_if, resp_ls;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IF;
         last_owner_q <= OWN_IF;
         drop_q       <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         drop_q       <= drop_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      drop_d       = drop_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      pick_ls      = 1'b0;
      grant_if     = 1'b0;
      grant_ls     = 1'b0;
      resp_if      = 1'b0;
      resp_ls      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // On a tie, the requester not served last wins
            pick_ls = ls_req && (!if_req || last_owner_q == OWN_IF);
            if (if_req || ls_req) begin
               state_d = S_REQ;
               if (pick_ls) begin
                  grant_ls = 1'b1;
                  owner_d  = OWN_LS;
                  we_d     = ls_we;
                  addr_d   = ls_addr;
                  wdata_d  = ls_wdata;
                  wmask_d  = ls_wmask;
                  drop_d   = 1'b0;
               end else begin
                  grant_if = 1'b1;
                  owner_d  = OWN_IF;
                  we_d     = 1'b0;
                  addr_d   = if_addr;
                  wdata_d  = '0;
                  wmask_d  = '0;
                  drop_d   = if_kill;
               end
            end
         end
         S_REQ: begin
            if (if_kill && owner_q == OWN_IF) drop_d = 1'b1;
            if (bus_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (if_kill && owner_q == OWN_IF) drop_d = 1'b1;
            if (bus_resp) begin
               // A kill arriving with the response itself also discards it
               resp_if      = (owner_q == OWN_IF) && !drop_q && !if_kill;
               resp_ls      = (owner_q == OWN_LS);
               last_owner_d = owner_q;
               drop_d       = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      if_gnt    = rst && grant_if;
      ls_gnt    = rst && grant_ls;
      if_rvalid = rst && resp_if;
      ls_rvalid = rst && resp_ls;
      if_rdata  = if_rvalid ? bus_rdata : '0;
      ls_rdata  = ls_rvalid ? bus_rdata : '0;
      bus_req   = rst && (state_q == S_REQ);
      bus_we    = we_q;
      bus_addr  = addr_q;
      bus_wdata = wdata_q;
      bus_wmask = wmask_q;
   end

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Bench for ysyx_220053_mem_arbiter: table of transactions plus hand sequences,
// with a response scoreboard queue checked whenever an rvalid appears.
module tb_ysyx_220053_mem_arbiter;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            if_req, if_kill, ls_req, ls_we;
   logic [AW-1:0]   if_addr, ls_addr;
   logic [DW-1:0]   ls_wdata;
   logic [DW/8-1:0] ls_wmask;
   logic            if_gnt, if_rvalid, ls_gnt, ls_rvalid;
   logic [DW-1:0]   if_rdata, ls_rdata;
   logic            bus_req, bus_we, bus_ready, bus_resp;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_wdata, bus_rdata;
   logic [DW/8-1:0] bus_wmask;

   ysyx_220053_mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_kill(if_kill),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wmask(bus_wmask), .bus_ready(bus_ready), .bus_resp(bus_resp), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_ls;
      logic [63:0] data;
   } exp_t;

   typedef struct {
      bit          is_ls;
      bit          we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic [63:0] rdata;
      int unsigned stall;
      int unsigned delay;
      bit          kill;
      bit          spur;
      bit          exp_resp;
   } vec_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   gnt_cyc = 0;
   int   rvalid_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every rvalid must match the oldest expected response
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] got;
      if (if_rvalid || ls_rvalid) begin
         rvalid_cyc = cyc;
         got = ls_rvalid ? ls_rdata : if_rdata;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid: got if_rvalid=%0b ls_rvalid=%0b data=%h, required none",
                     if_rvalid, ls_rvalid, got);
         end else begin
            e = exp_q.pop_front();
            if (ls_rvalid !== e.is_ls || if_rvalid !== !e.is_ls || got !== e.data ||
                (ls_rvalid ? if_rdata : ls_rdata) !== 64'h0) begin
               errors++;
               $display("FAIL resp: got if_rvalid=%0b ls_rvalid=%0b data=%h, required is_ls=%0b data=%h",
                        if_rvalid, ls_rvalid, got, e.is_ls, e.data);
            end
         end
      end else begin
         checks++;
         if (if_rdata !== 64'h0 || ls_rdata !== 64'h0) begin
            errors++;
            $display("FAIL idle_rdata: got if_rdata=%h ls_rdata=%h, required 0", if_rdata, ls_rdata);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cmd(input bit ereq, input bit ew, input logic [63:0] ea,
                            input logic [63:0] ed, input logic [7:0] em, input string name);
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wmask} !== {ereq, ew, ea, ed, em}) begin
         errors++;
         $display("FAIL %s_cmd: got req=%0b we=%0b addr=%h wdata=%h wmask=%h, required req=%0b we=%0b addr=%h wdata=%h wmask=%h",
                  name, bus_req, bus_we, bus_addr, bus_wdata, bus_wmask, ereq, ew, ea, ed, em);
      end
   endtask

   task automatic wait_gnt(input bit want_ls, input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (if_gnt || ls_gnt) seen = 1'b1;
      end
      gnt_cyc = cyc;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_gnt: got no grant in 20 cycles, required ls=%0b", name, want_ls);
      end else if (ls_gnt !== want_ls || if_gnt !== !want_ls || bus_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_gnt: got if_gnt=%0b ls_gnt=%0b bus_req=%0b, required ls=%0b bus_req=0",
                  name, if_gnt, ls_gnt, bus_req, want_ls);
      end
      tick();
   endtask

   // Called just after the grant edge; leaves the DUT back in IDLE
   task automatic bus_serve(input int unsigned stall, input int unsigned delay,
                            input logic [63:0] rdata, input bit ew, input logic [63:0] ea,
                            input logic [63:0] ed, input logic [7:0] em,
                            input bit kill, input bit spur, input string name);
      for (int s = 0; s < int'(stall); s++) begin
         if (spur && s == 0) begin
            bus_resp  = 1'b1;
            bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
         end
         @(negedge clk);
         check_cmd(1'b1, ew, ea, ed, em, name);
         tick();
         bus_resp  = 1'b0;
         bus_rdata = '0;
      end
      bus_ready = 1'b1;
      @(negedge clk);
      check_cmd(1'b1, ew, ea, ed, em, name);
      tick();
      bus_ready = 1'b0;
      for (int d = 0; d < int'(delay); d++) begin
         if (kill && d == 0) if_kill = 1'b1;
         @(negedge clk);
         checks++;
         if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait: got bus_req=%0b, required 0", name, bus_req);
         end
         tick();
         if_kill = 1'b0;
      end
      bus_resp  = 1'b1;
      bus_rdata = rdata;
      @(negedge clk);
      tick();
      bus_resp  = 1'b0;
      bus_rdata = '0;
   endtask

   task automatic check_latency(input int want, input string name);
      checks++;
      if (rvalid_cyc - gnt_cyc !== want) begin
         errors++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, rvalid_cyc - gnt_cyc, want);
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      exp_t e;
      if (v.is_ls) begin
         ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata; ls_wmask = v.wmask;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      if (v.exp_resp) begin
         e.is_ls = v.is_ls;
         e.data  = v.rdata;
         exp_q.push_back(e);
      end
      rvalid_cyc = -1;
      wait_gnt(v.is_ls, name);
      if_req = 1'b0;
      ls_req = 1'b0;
      if (v.is_ls)
         bus_serve(v.stall, v.delay, v.rdata, v.we, v.addr, v.wdata, v.wmask, v.kill, v.spur, name);
      else
         bus_serve(v.stall, v.delay, v.rdata, 1'b0, v.addr, 64'h0, 8'h0, v.kill, v.spur, name);
      if (v.exp_resp) check_latency(int'(2 + v.stall + v.delay), name);
   endtask

   function automatic vec_t mk(input bit is_ls, input bit we, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [7:0] wmask,
                               input logic [63:0] rdata, input int unsigned stall,
                               input int unsigned delay, input bit kill, input bit spur,
                               input bit exp_resp);
      vec_t v;
      v.is_ls = is_ls; v.we = we; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
      v.rdata = rdata; v.stall = stall; v.delay = delay; v.kill = kill; v.spur = spur;
      v.exp_resp = exp_resp;
      return v;
   endfunction

   vec_t vecs[8];

   initial begin
      exp_t e;
      vecs[0] = mk(0, 0, 64'h8000_0004, 64'h0, 8'h00, 64'h0000_0013, 0, 0, 0, 0, 1);
      vecs[1] = mk(1, 0, 64'h8000_2000, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1, 1, 0, 0, 1);
      vecs[2] = mk(1, 1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'h0, 3, 1, 0, 1, 1);
      vecs[3] = mk(0, 0, 64'h8000_0040, 64'h0, 8'h00, 64'hCAFE_F00D, 2, 3, 0, 1, 1);
      vecs[4] = mk(0, 0, 64'h8000_0080, 64'h0, 8'h00, 64'h5555_AAAA, 0, 2, 1, 0, 0);
      vecs[5] = mk(1, 0, 64'h8000_3000, 64'h0, 8'h00, 64'h0BAD_C0DE_1234_5678, 0, 2, 1, 0, 1);
      vecs[6] = mk(1, 1, '1, '1, 8'hFF, 64'h0, 0, 4, 0, 0, 1);
      vecs[7] = mk(0, 0, 64'h0, 64'h0, 8'h00, '1, 0, 0, 0, 0, 1);

      rst = 1'b0; if_req = 1'b1; if_kill = 1'b0; ls_req = 1'b1; ls_we = 1'b0;
      if_addr = 64'h1234; ls_addr = 64'h5678; ls_wdata = '0; ls_wmask = '0;
      bus_ready = 1'b0; bus_resp = 1'b0; bus_rdata = '0;

      // Reset: grants and bus_req held low even with requests pending
      tick();
      @(negedge clk);
      checks++;
      if ({if_gnt, ls_gnt, bus_req, if_rvalid, ls_rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got gnt=%0b/%0b bus_req=%0b rvalid=%0b/%0b, required all 0",
                  if_gnt, ls_gnt, bus_req, if_rvalid, ls_rvalid);
      end
      tick();
      if_req = 1'b0; ls_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_cmd(1'b0, 1'b0, 64'h0, 64'h0, 8'h0, "post_reset");
      tick();

      // Single fetch: rvalid four cycles after grant
      run_vec(mk(0, 0, 64'h8000_0000, 64'h0, 8'h00, 64'h0010_0073, 0, 2, 0, 0, 1), "single_fetch");

      // Tie: both held, alternation LS, IF, LS, IF
      if_req = 1'b1; if_addr = 64'h8000_0100;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_0200; ls_wdata = 64'h77; ls_wmask = 8'h3C;
      for (int k = 0; k < 4; k++) begin
         e.is_ls = (k % 2 == 0);
         e.data  = 64'hA000_0000 + 64'(k);
         exp_q.push_back(e);
         wait_gnt(e.is_ls, "tie");
         if (k > 0) begin
            checks++;
            if (gnt_cyc !== rvalid_cyc + 1) begin
               errors++;
               $display("FAIL tie_regrant: got grant at cycle %0d, required %0d", gnt_cyc, rvalid_cyc + 1);
            end
         end
         if (e.is_ls)
            bus_serve(0, 1, e.data, 1'b0, 64'h8000_0200, 64'h77, 8'h3C, 0, 0, "tie");
         else
            bus_serve(0, 1, e.data, 1'b0, 64'h8000_0100, 64'h0, 8'h00, 0, 0, "tie");
      end
      if_req = 1'b0; ls_req = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Kill in the grant cycle: grant stands, response dropped
      if_req = 1'b1; if_kill = 1'b1; if_addr = 64'h8000_0400;
      wait_gnt(1'b0, "kill_at_gnt");
      if_req = 1'b0; if_kill = 1'b0;
      bus_serve(0, 1, 64'h1111, 1'b0, 64'h8000_0400, 64'h0, 8'h0, 0, 0, "kill_at_gnt");

      // Spurious response in IDLE
      bus_resp = 1'b1; bus_rdata = 64'hFEED;
      tick();
      bus_resp = 1'b0; bus_rdata = '0;
      tick();

      // Reset while waiting for the response; later response is ignored
      if_req = 1'b1; if_addr = 64'h8000_0800;
      wait_gnt(1'b0, "rst_wait");
      if_req = 1'b0;
      bus_ready = 1'b1;
      @(negedge clk);
      check_cmd(1'b1, 1'b0, 64'h8000_0800, 64'h0, 8'h0, "rst_wait");
      tick();
      bus_ready = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      bus_resp = 1'b1; bus_rdata = 64'h2222;
      @(negedge clk);
      check_cmd(1'b0, 1'b0, 64'h0, 64'h0, 8'h0, "rst_wait_after");
      tick();
      bus_resp = 1'b0; bus_rdata = '0;
      run_vec(mk(1, 0, 64'h8000_4000, 64'h0, 8'h00, 64'h3333_4444, 0, 1, 0, 0, 1), "after_rst");

      tick();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d outstanding responses, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
